// File: rtl/fp_pkg.sv
// Shared numeric constants, FSM state type and operand classifier for the FP arithmetic pipe.
package fp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  // Returns {is_zero, is_inf, is_nan}; a zero exponent is a zero (denormals flushed).
  function automatic logic [2:0] classify(input logic [30:0] f);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = f[30:23];
    m = f[22:0];
    classify = {(e == '0), (e == '1) && (m == '0), (e == '1) && (m != '0)};
  endfunction

endpackage

// File: rtl/mant_seq_mul.sv
// 24x24 shift-add mantissa multiplier, one multiplier bit per cycle, LSB first.
module mant_seq_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] op_a,
  input  logic [23:0] op_b,
  output logic        done,
  output logic [47:0] prod
);

  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Load on start, then add the shifted multiplicand for each set multiplier bit.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {24'h00_0000, op_a};
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == 5'd23) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/fp_mul_iterative.sv
// Sequential IEEE-754 single multiplier: truncating, flush-to-zero, valid/ready on both sides.
module fp_mul_iterative
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Product
);

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [31:0]        product_q, product_d;
  logic               out_valid_q, out_valid_d;

  logic [2:0]         cls_a, cls_b;
  logic               sign_in, is_special, accept;
  logic [31:0]        spec_val, norm_res;
  logic signed [9:0]  e_norm;
  logic [22:0]        mant;
  logic               mul_done;
  logic [47:0]        mul_prod;
  logic               unused_prod;

  assign cls_a    = classify(Multiplicand[30:0]);
  assign cls_b    = classify(Multiplier[30:0]);
  assign sign_in  = Multiplicand[31] ^ Multiplier[31];
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && (state_q == IDLE);

  mant_seq_mul u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && !is_special),
    .op_a  ({1'b1, Multiplicand[22:0]}),
    .op_b  ({1'b1, Multiplier[22:0]}),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign unused_prod = ^mul_prod[22:0];

  // Special-operand result, decided from the incoming operands at accept.
  always_comb begin
    is_special = (|cls_a) || (|cls_b);
    if (cls_a[0] || cls_b[0] || (cls_a[1] && cls_b[2]) || (cls_a[2] && cls_b[1]))
      spec_val = QNAN;
    else if (cls_a[1] || cls_b[1])
      spec_val = {sign_in, 8'hFF, 23'h00_0000};
    else
      spec_val = {sign_in, 31'h0000_0000};
  end

  // Normalisation, overflow/underflow and packing of the finished mantissa product.
  always_comb begin
    e_norm = exp_q + (mul_prod[47] ? 10'sd1 : 10'sd0);
    mant   = mul_prod[47] ? mul_prod[46:24] : mul_prod[45:23];
    if (spec_q)
      norm_res = spec_res_q;
    else if (e_norm >= 10'sd255)
      norm_res = {sign_q, 8'hFF, 23'h00_0000};
    else if (e_norm <= 10'sd0)
      norm_res = {sign_q, 31'h0000_0000};
    else
      norm_res = {sign_q, e_norm[7:0], mant};
  end

  // Handshake FSM. Special operands bypass MUL and spend their single pre-DONE
  // cycle in NORM, which passes the precomputed result straight through.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = sign_in;
          exp_d      = 10'(Multiplicand[30:23]) + 10'(Multiplier[30:23]) - 10'(BIAS);
          spec_d     = is_special;
          spec_res_d = spec_val;
          state_d    = is_special ? NORM : MUL;
        end
      end
      MUL: begin
        if (mul_done) state_d = NORM;
      end
      NORM: begin
        product_d   = norm_res;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      spec_q      <= spec_d;
      spec_res_q  <= spec_res_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Product   = product_q;

endmodule

// File: tb/tb_fp_mul_iterative.sv
// Directed and randomized checks of the iterative FP multiplier against an arithmetic reference.
module tb_fp_mul_iterative;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, prod;

  int vectors = 0;
  int miscompares = 0;

  fp_mul_iterative dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Multiplicand (a),
    .Multiplier   (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Product      (prod)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product of the 24-bit significands, scaled and truncated.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic         s;
    int           ex, ey, e;
    longint unsigned mx, my, p, m;
    bit           zx, zy, ix, iy, nx, ny;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]);
    my = longint'(y[22:0]);
    zx = (ex == 0);   zy = (ey == 0);
    ix = (ex == 255) && (mx == 0);  iy = (ey == 255) && (my == 0);
    nx = (ex == 255) && (mx != 0);  ny = (ey == 255) && (my != 0);
    if (nx || ny || (ix && zy) || (zx && iy)) return 32'h7FC0_0000;
    if (ix || iy) return {s, 8'hFF, 23'h0};
    if (zx || zy) return {s, 31'h0};
    p = (mx + 64'h80_0000) * (my + 64'h80_0000);
    e = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin
      e = e + 1;
      m = (p >> 24) & 64'h7F_FFFF;
    end else begin
      m = (p >> 23) & 64'h7F_FFFF;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(m)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for result, optional back-pressure, handshake.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold, input bit pulse);
    int          n;
    int          exp_lat;
    logic [31:0] exp_p;
    bit          special;
    exp_p   = ref_mul(x, y);
    special = (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
              (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    exp_lat = special ? 1 : 26;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_idle", {31'h0, in_ready}, 32'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    check("in_ready_busy", {31'h0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = pulse && (n == 3 || n == 8);
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(exp_lat));
    check("product", prod, exp_p);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_product", prod, exp_p);
      check("hold_valid", {31'h0, out_valid}, 32'd1);
      check("hold_in_ready", {31'h0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", {31'h0, out_valid}, 32'd0);
    check("drain_in_ready", {31'h0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] m;
    int          r;
    r = int'($urandom_range(0, 9));
    m = 23'($urandom);
    if (r == 0) e = 8'h00;
    else if (r == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else e = 8'($urandom_range(64, 190));
    return {1'($urandom), e, m};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'h0, out_valid}, 32'd0);
    check("reset_product", prod, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    rst_n = 1'b1;

    run_op(32'h3FC0_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'hC040_0000, 32'h3F00_0000, 0, 1'b0);
    run_op(32'h3F80_0001, 32'h3F80_0001, 0, 1'b0);
    run_op(32'h7F00_0000, 32'h7F00_0000, 0, 1'b0);
    run_op(32'h0080_0000, 32'h0080_0000, 0, 1'b0);
    run_op(32'h0000_0000, 32'hC000_0000, 0, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 0, 1'b0);
    run_op(32'hFF80_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'h7FA0_0001, 32'h3F80_0000, 0, 1'b0);
    run_op(32'h3FC0_0000, 32'h4000_0000, 5, 1'b0);
    run_op(32'hC040_0000, 32'h3F00_0000, 0, 1'b1);

    // Reset on the 10th cycle of MUL discards the operation.
    a = 32'h3FC0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_valid", {31'h0, out_valid}, 32'd0);
    check("midreset_product", prod, 32'h0);
    check("midreset_in_ready", {31'h0, in_ready}, 32'd1);
    rst_n = 1'b1;
    run_op(32'h3FC0_0000, 32'h4000_0000, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_op(rand_operand(), rand_operand(), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
